// File: rtl/d_latch_checker.sv
// ============================================================================
// Module  : d_latch_checker
// Brief   : Response checker for a gated D latch: samples en/d/q/qbar, tracks
//           expected latch state, compares after a settle window, counts
//           checks and errors. Optional macro QBAR_CHECK_EN enables the
//           q/qbar complement check.
// Revision: 1.0
// ============================================================================
`default_nettype none

module d_latch_checker #(
  parameter int SETTLE = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             d,
  input  logic             q,
  input  logic             qbar,
  output logic             err_pulse,
  output logic [1:0]       err_code,
  output logic [1:0]       first_err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] check_cnt,
  output logic             pass
);

  localparam int SW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam logic [SW-1:0]    C_SETTLE  = SW'(SETTLE);
  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_UNKNOWN = 2'd0,
    S_SETTLE  = 2'd1,
    S_CHECK   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [SW-1:0]    settle_cnt_q, settle_cnt_d;
  logic             en_r_q, d_r_q, q_r_q, qbar_r_q;
  logic             exp_val_q, exp_val_d;
  logic             exp_known_q, exp_known_d;
  logic             err_pulse_q, err_pulse_d;
  logic [1:0]       err_code_q, err_code_d;
  logic [1:0]       first_err_q, first_err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] check_cnt_q, check_cnt_d;
  logic             pass_q, pass_d;

  logic w_rel_chg;
  logic w_do_cmp;
  logic w_mis_q;
  logic w_mis_c;
  logic w_mis;

  // d changes only matter while the latch is transparent
  assign w_rel_chg = (en != en_r_q) | (en & (d != d_r_q));
  assign w_mis_q   = (q_r_q != exp_val_q);

`ifdef QBAR_CHECK_EN
  assign w_mis_c = (q_r_q == qbar_r_q);
`else
  logic w_unused_qbar;
  assign w_unused_qbar = qbar_r_q;
  assign w_mis_c       = 1'b0;
`endif

  assign w_mis = w_do_cmp & (w_mis_q | w_mis_c);

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    w_do_cmp     = 1'b0;
    case (state_q)
      S_UNKNOWN: begin
        if (en_r_q) begin
          state_d      = S_SETTLE;
          settle_cnt_d = C_SETTLE;
        end
      end
      S_SETTLE: begin
        if (w_rel_chg) begin
          settle_cnt_d = C_SETTLE;
        end else if (settle_cnt_q == '0) begin
          state_d = S_CHECK;
        end else begin
          settle_cnt_d = settle_cnt_q - 1'b1;
        end
      end
      S_CHECK: begin
        if (w_rel_chg) begin
          state_d      = S_SETTLE;
          settle_cnt_d = C_SETTLE;
        end else begin
          w_do_cmp = 1'b1;
        end
      end
      default: begin
        state_d      = S_UNKNOWN;
        settle_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    exp_val_d   = en_r_q ? d_r_q : exp_val_q;
    exp_known_d = exp_known_q | en_r_q;
    err_pulse_d = w_mis;
    err_code_d  = w_mis ? {w_mis_c, w_mis_q} : err_code_q;
    first_err_d = (w_mis && (err_cnt_q == '0)) ? {w_mis_c, w_mis_q} : first_err_q;
    check_cnt_d = check_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (w_do_cmp && (check_cnt_q != C_CNT_MAX)) begin
      check_cnt_d = check_cnt_q + 1'b1;
    end
    if (w_mis && (err_cnt_q != C_CNT_MAX)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
    pass_d = exp_known_d & (err_cnt_d == '0) & (check_cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_UNKNOWN;
      settle_cnt_q <= '0;
      en_r_q       <= 1'b0;
      d_r_q        <= 1'b0;
      q_r_q        <= 1'b0;
      qbar_r_q     <= 1'b0;
      exp_val_q    <= 1'b0;
      exp_known_q  <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_code_q   <= 2'b00;
      first_err_q  <= 2'b00;
      err_cnt_q    <= '0;
      check_cnt_q  <= '0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      en_r_q       <= en;
      d_r_q        <= d;
      q_r_q        <= q;
      qbar_r_q     <= qbar;
      exp_val_q    <= exp_val_d;
      exp_known_q  <= exp_known_d;
      err_pulse_q  <= err_pulse_d;
      err_code_q   <= err_code_d;
      first_err_q  <= first_err_d;
      err_cnt_q    <= err_cnt_d;
      check_cnt_q  <= check_cnt_d;
      pass_q       <= pass_d;
    end
  end

  assign err_pulse = err_pulse_q;
  assign err_code  = err_code_q;
  assign first_err = first_err_q;
  assign err_cnt   = err_cnt_q;
  assign check_cnt = check_cnt_q;
  assign pass      = pass_q;

endmodule

`default_nettype wire

// File: tb/tb_d_latch_checker.sv
// ============================================================================
// Module  : tb_d_latch_checker
// Brief   : Randomized self-checking bench for d_latch_checker against a
//           history-based model of the checking rules.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_d_latch_checker;

  localparam int SETTLE = 2;
  localparam int CNT_W  = 8;
  localparam int MAXC   = (1 << CNT_W) - 1;
  localparam int HLEN   = 8192;
`ifdef QBAR_CHECK_EN
  localparam bit QB_ON = 1'b1;
`else
  localparam bit QB_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst, en, d, q, qbar;
  wire              err_pulse;
  wire [1:0]        err_code, first_err;
  wire [CNT_W-1:0]  err_cnt, check_cnt;
  wire              pass;

  d_latch_checker #(.SETTLE(SETTLE), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .d(d), .q(q), .qbar(qbar),
    .err_pulse(err_pulse), .err_code(err_code), .first_err(first_err),
    .err_cnt(err_cnt), .check_cnt(check_cnt), .pass(pass)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Post-reset input history, one entry per clock edge
  bit en_h [HLEN];
  bit d_h  [HLEN];
  bit q_h  [HLEN];
  bit qb_h [HLEN];
  int t;

  bit       act;
  int       last_trig;
  int       m_checks, m_errs;
  bit [1:0] m_code, m_first;
  bit       m_pulse;
  bit       lat = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", name, got, want, t);
    end
  endtask

  // Expected latch value seen by a compare at index tt: last d driven while en=1, two edges back
  function automatic bit exp_at(input int tt);
    for (int k = tt - 2; k >= 0; k--) begin
      if (en_h[k]) return d_h[k];
    end
    return 1'b0;
  endfunction

  task automatic model_edge();
    bit enp, dp, qr, qbr, rel, cmp, mq, mc;
    if (rst) begin
      t = 0; act = 0; last_trig = 0;
      m_checks = 0; m_errs = 0; m_code = 0; m_first = 0; m_pulse = 0;
      return;
    end
    if (t >= HLEN) begin
      $display("FAIL history: got %0d expected <%0d", t, HLEN);
      bad++;
      $fatal(1, "history overflow");
    end
    en_h[t] = en; d_h[t] = d; q_h[t] = q; qb_h[t] = qbar;
    enp = (t > 0) ? en_h[t-1] : 1'b0;
    dp  = (t > 0) ? d_h[t-1]  : 1'b0;
    qr  = (t > 0) ? q_h[t-1]  : 1'b0;
    qbr = (t > 0) ? qb_h[t-1] : 1'b0;
    rel = (en != enp) || (en && (d != dp));
    cmp = 1'b0;
    m_pulse = 1'b0;
    if (!act) begin
      if (enp) begin act = 1; last_trig = t; end
    end else if (rel) begin
      last_trig = t;
    end else if (t - last_trig >= SETTLE + 2) begin
      cmp = 1'b1;
    end
    if (cmp) begin
      mq = (qr != exp_at(t));
      mc = QB_ON && (qr == qbr);
      if (m_checks < MAXC) m_checks++;
      if (mq || mc) begin
        m_pulse = 1'b1;
        m_code  = {mc, mq};
        if (m_errs == 0) m_first = {mc, mq};
        if (m_errs < MAXC) m_errs++;
      end
    end
    t++;
  endtask

  task automatic compare_all();
    chk("err_pulse", err_pulse, m_pulse);
    chk("err_code",  err_code,  m_code);
    chk("first_err", first_err, m_first);
    chk("err_cnt",   err_cnt,   m_errs);
    chk("check_cnt", check_cnt, m_checks);
    chk("pass",      pass,      act && m_errs == 0 && m_checks != 0);
  endtask

  // fq: <0 ideal q, else forced value; fqb: <0 complement of q, 2 = copy of q, else forced value
  task automatic step(input bit r, input bit e, input bit dv, input int fq, input int fqb);
    @(negedge clk);
    rst = r; en = e; d = dv;
    if (e) lat = dv;
    q    = (fq < 0) ? lat : fq[0];
    qbar = (fqb < 0) ? ~q : (fqb == 2) ? q : fqb[0];
    @(posedge clk);
    model_edge();
    #1 compare_all();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; d = 1'b0; q = 1'b0; qbar = 1'b1;

    // Reset, then d toggling with en low
    repeat (2) step(1, 0, 0, -1, -1);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_check_cnt", check_cnt, 0);
    chk("rst_pass", pass, 0);
    chk("rst_first_err", first_err, 0);
    for (int i = 0; i < 10; i++) step(0, 0, i[0], -1, -1);
    chk("en0_no_checks", check_cnt, 0);

    // Transparent hold at 0 then 1
    for (int i = 0; i < 10; i++) step(0, 1, 0, -1, -1);
    for (int i = 0; i < 10; i++) step(0, 1, 1, -1, -1);
    chk("hold_check_cnt", check_cnt, 11);
    chk("hold_err_cnt", err_cnt, 0);
    chk("hold_pass", pass, 1);

    // Opaque with d toggling: checks continue, q stays 1
    for (int i = 0; i < 10; i++) step(0, 0, i[0], -1, -1);
    chk("opaque_check_cnt", check_cnt, 17);
    chk("opaque_err_cnt", err_cnt, 0);

    // Faulty DUT: q stuck at 0 during opaque hold
    for (int i = 0; i < 6; i++) step(0, 0, 1'($urandom), 0, -1);
    chk("fault_err_cnt", err_cnt, 5);
    chk("fault_err_code", err_code, 1);
    chk("fault_first_err", first_err, 1);
    chk("fault_pass", pass, 0);

    // qbar faults
    step(1, 0, 0, -1, -1);
    for (int i = 0; i < 8; i++) step(0, 1, 1, -1, -1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, -1, 2);
`ifdef QBAR_CHECK_EN
    chk("qbar_err_code", err_code, 2);
`else
    chk("qbar_ignored", err_cnt, 0);
`endif
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 2);
`ifdef QBAR_CHECK_EN
    chk("both_err_code", err_code, 3);
`else
    chk("both_err_code", err_code, 1);
`endif

    // Randomized traffic with sporadic faults
    step(1, 0, 0, -1, -1);
    begin
      bit e = 0;
      for (int i = 0; i < 1500; i++) begin
        int fq, fqb;
        if ($urandom_range(0, 7) == 0) e = ~e;
        fq  = ($urandom_range(0, 29) == 0) ? int'($urandom_range(0, 1)) : -1;
        fqb = ($urandom_range(0, 29) == 0) ? 2 : -1;
        step(0, e, ($urandom_range(0, 3) == 0) ? ~d : d, fq, fqb);
      end
    end

    // Saturation and mid-check reset
    step(1, 0, 0, -1, -1);
    for (int i = 0; i < 6; i++) step(0, 1, 0, -1, -1);
    for (int i = 0; i < 300; i++) step(0, 0, 1'($urandom), 1, -1);
    chk("sat_err_cnt", err_cnt, MAXC);
    chk("sat_check_cnt", check_cnt, MAXC);
    step(1, 0, 0, 1, -1);
    chk("midrst_err_cnt", err_cnt, 0);
    chk("midrst_check_cnt", check_cnt, 0);
    chk("midrst_first_err", first_err, 0);
    chk("midrst_err_pulse", err_pulse, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, -1, -1);
    chk("post_rst_no_checks", check_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
